mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Multiply/divide unit with architectural HI/LO registers, in the E stage of the pipelined MIPS CPU.
- Takes rs/rt operand values (already forwarded) and runs MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency.
- Services MTHI/MTLO writes and provides HI/LO read data for MFHI/MFLO, which travels down the pipeline to the register-file write port.
- Raises busy so the hazard unit can stall dependent MDU instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- A  in  32  rs operand (dividend / multiplicand; MTHI/MTLO source).
- B  in  32  rt operand (divisor / multiplier).
- start  in  1  one-cycle pulse launching the op on md_op.
- md_op  in  2  0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU.
- hi_we  in  1  MTHI: write A into HI.
- lo_we  in  1  MTLO: write A into LO.
- rd_sel  in  1  read select: 0 = LO, 1 = HI.
- rd_data  out  32  combinational HI or LO per rd_sel.
- busy  out  1  operation in flight.
- stall_req  out  1  combinational start | busy, consumed by the hazard unit.

Behaviour:
- Reset: on a clk edge with clr=1, the block clears HI=0, LO=0, busy=0 and the counter=0. clr overrides every other input in the same cycle.
- An operation in flight is discarded on clr. No partial result is written.
- States: IDLE (busy=0) and RUN (busy=1).
- IDLE to RUN: edge with start=1.
  - The full result is computed from A/B and md_op at that edge and held in internal temp_hi/temp_lo.
  - The counter loads MULT_CYCLES or DIV_CYCLES.
- RUN: each edge decrements the counter.
  - On the edge where the counter equals 1, the block sets HI=temp_hi, LO=temp_lo, busy=0 and returns to IDLE.
  - busy is therefore high for exactly N cycles after the start edge.
  - rd_data reflects the new HI/LO in the first cycle busy=0.
- MULT: signed 32x32 to 64-bit product; HI = [63:32], LO = [31:0].
- MULTU: same layout, unsigned.
- DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (B=0): the operation still occupies DIV_CYCLES. HI/LO are left unchanged at completion.
- hi_we/lo_we in IDLE: write A at the edge. Both may be asserted together.
- hi_we/lo_we together with start in the same cycle: start wins; the writes are ignored.
- start, hi_we or lo_we while busy=1: ignored. The operands are not captured and the running op is unaffected. The hazard unit guarantees this never occurs legally; the block must still be safe.
- rd_data is purely combinational from the HI/LO registers. It never exposes temp values while busy.
- start=1 with clr=1: treated as reset; busy stays 0.

Test Plan:
- Reset then rd_sel=0/1: rd_data=0 both. busy=0. stall_req=0.
- MULT A=0xFFFFFFFE(-2), B=3, one start pulse:
  - stall_req=1 in the start cycle; busy=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MULTU with the same operands: HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9(-7), B=2: busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU A=7, B=2: LO=3, HI=1.
  - DIV 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 in IDLE: rd_data matches on the next cycle.
  - Then start DIV with B=0: busy 10 cycles; HI/LO still 0x12345678/0x9ABCDEF0.
- During MULT busy (cycle 3), pulse start DIV and hi_we with A=0xDEAD:
  - Ignored. Completion occurs at the original cycle with the MULT result. HI is not 0xDEAD.
- Start DIV, assert clr at busy cycle 4:
  - Next cycle busy=0, HI=LO=0. No later write-back occurs.
  - A new MULT started immediately after completes normally.

Source files
------------

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - multi-cycle multiply/divide unit with architectural HI/LO registers
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        stall_req
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [31:0]   hi, lo, temp_hi, temp_lo;
  logic          temp_wr;

  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, div_b, quo_u, rem_u, quo_s, rem_s;
  logic [31:0] res_hi, res_lo;
  logic        is_div, div_zero, signed_div;

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    is_div     = md_op[1];
    signed_div = (md_op == 2'd2);
    div_zero   = (B == 32'd0);
    prod_s     = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u     = {32'd0, A} * {32'd0, B};
    mag_a      = (signed_div && A[31]) ? (~A + 32'd1) : A;
    mag_b      = (signed_div && B[31]) ? (~B + 32'd1) : B;
    div_b      = div_zero ? 32'd1 : mag_b;
    quo_u      = mag_a / div_b;
    rem_u      = mag_a % div_b;
    quo_s      = (A[31] ^ B[31]) ? (~quo_u + 32'd1) : quo_u;
    rem_s      = A[31] ? (~rem_u + 32'd1) : rem_u;
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    case (md_op)
      2'd0: {res_hi, res_lo} = prod_s;
      2'd1: {res_hi, res_lo} = prod_u;
      2'd2: {res_hi, res_lo} = {rem_s, quo_s};
      default: {res_hi, res_lo} = {rem_u, quo_u};
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      busy    <= 1'b0;
      count   <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      temp_hi <= 32'd0;
      temp_lo <= 32'd0;
      temp_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            temp_hi <= res_hi;
            temp_lo <= res_lo;
            temp_wr <= !(is_div && div_zero);
            count   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            if (hi_we) hi <= A;
            if (lo_we) lo <= A;
          end
        end
        default: begin
          if (count == CW'(1)) begin
            if (temp_wr) begin
              hi <= temp_hi;
              lo <= temp_lo;
            end
            count <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            count <= count - CW'(1);
          end
        end
      endcase
    end
  end

  assign rd_data   = rd_sel ? hi : lo;
  assign stall_req = start | busy;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - directed-vector bench for mdu_hilo
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] A, B;
  logic        start;
  logic [1:0]  md_op;
  logic        hi_we, lo_we, rd_sel;
  logic [31:0] rd_data;
  logic        busy, stall_req;

  int vectors = 0;
  int errors  = 0;

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .clr(clr), .A(A), .B(B), .start(start), .md_op(md_op),
    .hi_we(hi_we), .lo_we(lo_we), .rd_sel(rd_sel), .rd_data(rd_data),
    .busy(busy), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    rd_sel = 1'b1;
    #1 h = rd_data;
    rd_sel = 1'b0;
    #1 l = rd_data;
  endtask

  // Launch an op and count sampled cycles with busy=1 (bounded).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    A = a; B = b; md_op = op; start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 50) begin
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    logic [31:0] h, l;
    clr = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; rd_sel = 1'b0;
    A = 32'd0; B = 32'd0; md_op = 2'd0;
    tick(); tick();
    clr = 1'b0;
    read_hilo(h, l);
    vectors++; if (h !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", h); end
    vectors++; if (l !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", l); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_req); end
  endtask

  task automatic test_mult();
    logic [31:0] h, l;
    int n;
    A = 32'hFFFFFFFE; B = 32'd3; md_op = 2'd0; start = 1'b1;
    #1;
    vectors++; if (stall_req !== 1'b1) begin errors++; $display("FAIL mult_stall_start got %b want 1", stall_req); end
    run_op(2'd0, 32'hFFFFFFFE, 32'd3, n);
    vectors++; if (n !== 5) begin errors++; $display("FAIL mult_busy_cycles got %0d want 5", n); end
    read_hilo(h, l);
    vectors++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", h); end
    vectors++; if (l !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", l); end
    run_op(2'd1, 32'hFFFFFFFE, 32'd3, n);
    read_hilo(h, l);
    vectors++; if (h !== 32'h00000002) begin errors++; $display("FAIL multu_hi got %h want 00000002", h); end
    vectors++; if (l !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_lo got %h want fffffffa", l); end
  endtask

  task automatic test_div();
    logic [31:0] h, l;
    int n;
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, n);
    vectors++; if (n !== 10) begin errors++; $display("FAIL div_busy_cycles got %0d want 10", n); end
    read_hilo(h, l);
    vectors++; if (l !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", l); end
    vectors++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", h); end
    run_op(2'd3, 32'd7, 32'd2, n);
    read_hilo(h, l);
    vectors++; if (l !== 32'd3) begin errors++; $display("FAIL divu_lo got %h want 3", l); end
    vectors++; if (h !== 32'd1) begin errors++; $display("FAIL divu_hi got %h want 1", h); end
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, n);
    read_hilo(h, l);
    vectors++; if (l !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", l); end
    vectors++; if (h !== 32'd0) begin errors++; $display("FAIL div_ovf_hi got %h want 0", h); end
  endtask

  task automatic test_mthi_mtlo_divzero();
    logic [31:0] h, l;
    int n;
    A = 32'h12345678; hi_we = 1'b1;
    tick();
    hi_we = 1'b0;
    rd_sel = 1'b1; #1;
    vectors++; if (rd_data !== 32'h12345678) begin errors++; $display("FAIL mthi got %h want 12345678", rd_data); end
    A = 32'h9ABCDEF0; lo_we = 1'b1;
    tick();
    lo_we = 1'b0;
    rd_sel = 1'b0; #1;
    vectors++; if (rd_data !== 32'h9ABCDEF0) begin errors++; $display("FAIL mtlo got %h want 9abcdef0", rd_data); end
    run_op(2'd2, 32'd100, 32'd0, n);
    vectors++; if (n !== 10) begin errors++; $display("FAIL divzero_cycles got %0d want 10", n); end
    read_hilo(h, l);
    vectors++; if (h !== 32'h12345678) begin errors++; $display("FAIL divzero_hi got %h want 12345678", h); end
    vectors++; if (l !== 32'h9ABCDEF0) begin errors++; $display("FAIL divzero_lo got %h want 9abcdef0", l); end
  endtask

  task automatic test_ignore_while_busy();
    logic [31:0] h, l;
    int n;
    A = 32'hFFFFFFFE; B = 32'd3; md_op = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    tick(); n++;
    tick(); n++;
    A = 32'h0000DEAD; B = 32'd1; md_op = 2'd2; start = 1'b1; hi_we = 1'b1;
    tick();
    start = 1'b0; hi_we = 1'b0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    vectors++; if (n !== 5) begin errors++; $display("FAIL ignore_cycles got %0d want 5", n); end
    read_hilo(h, l);
    vectors++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL ignore_hi got %h want ffffffff", h); end
    vectors++; if (l !== 32'hFFFFFFFA) begin errors++; $display("FAIL ignore_lo got %h want fffffffa", l); end
  endtask

  task automatic test_clr_midop();
    logic [31:0] h, l;
    int n;
    A = 32'd7; B = 32'd2; md_op = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b want 0", busy); end
    read_hilo(h, l);
    vectors++; if (h !== 32'd0 || l !== 32'd0) begin errors++; $display("FAIL clr_hilo got %h/%h want 0/0", h, l); end
    for (int i = 0; i < 12; i++) tick();
    read_hilo(h, l);
    vectors++; if (h !== 32'd0 || l !== 32'd0) begin errors++; $display("FAIL clr_no_wb got %h/%h want 0/0", h, l); end
    run_op(2'd1, 32'd6, 32'd7, n);
    vectors++; if (n !== 5) begin errors++; $display("FAIL post_clr_cycles got %0d want 5", n); end
    read_hilo(h, l);
    vectors++; if (h !== 32'd0 || l !== 32'd42) begin errors++; $display("FAIL post_clr_result got %h/%h want 0/2a", h, l); end
  endtask

  task automatic test_start_with_clr();
    A = 32'd5; B = 32'd5; md_op = 2'd0; start = 1'b1; clr = 1'b1;
    tick();
    start = 1'b0; clr = 1'b0;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL start_clr_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo_divzero();
    test_ignore_while_busy();
    test_clr_midop();
    test_start_with_clr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
